led_blinker_bank: RTL and testbench

LED_BLINKER_BANK -- requirements
Module: led_blinker_bank

---
 rtl/led_blinker_bank_pkg.sv | 16 +
 rtl/led_blinker_bank_tick_prescaler.sv | 40 ++++
 rtl/led_blinker_bank.sv | 118 +++++++++++
 tb/tb_led_blinker_bank.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/led_blinker_bank_pkg.sv
// Shared constants for the LED blinker bank.
// Holds the channel mode encodings and the mode field width, so that the
// top level, any sub-blocks and any software-facing register map all use
// the same values.
package led_blinker_bank_pkg;

  localparam int MODE_W = 2;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_OFF   = 2'd0;
  localparam mode_t MODE_ON    = 2'd1;
  localparam mode_t MODE_BLINK = 2'd2;
  localparam mode_t MODE_PWM   = 2'd3;

endpackage

// File: rtl/led_blinker_bank_tick_prescaler.sv
// tick_prescaler: free-running clock divider producing a one-cycle TICK.
// Ports:
//   CLK   - clock, rising edge
//   RESET - synchronous active-high reset (counter cleared, TICK held low)
//   DIV   - period in CLK cycles; 0 behaves as 1
//   TICK  - high in the terminal cycle of each period
module tick_prescaler #(
  parameter int WIDTH = 26
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DIV,
  output logic             TICK
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] last;
  logic             term;

  // Terminal count is max(DIV,1)-1. Using >= rather than == means a DIV
  // lowered below the current count ends the period immediately instead of
  // letting the counter run all the way round.
  always_comb begin
    last = (DIV == '0) ? '0 : DIV - WIDTH'(1);
    term = (cnt >= last);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt <= '0;
    end else if (term) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + WIDTH'(1);
    end
  end

  assign TICK = term && !RESET;

endmodule

// File: rtl/led_blinker_bank.sv
// led_blinker_bank: bank of LED channels driven from a shared prescaled
// phase counter. Each channel is off, on, blinking (phase MSB) or PWM
// (phase < duty). Configuration is written into shadow registers and
// copied to the active set at the phase wrap so a period is never torn.
// Ports:
//   CLK, RESET          - clock and synchronous active-high reset
//   DIV                 - prescaler period in CLK cycles (0 behaves as 1)
//   CFG_VALID/CFG_READY - write handshake
//   CFG_CHAN            - target channel (out-of-range writes are dropped)
//   CFG_MODE, CFG_DUTY  - mode and PWM duty for the target channel
//   LED                 - registered per-channel drive
//   TICK                - prescaler wrap pulse
//   COUT                - phase counter wrap pulse
module led_blinker_bank
  import led_blinker_bank_pkg::*;
#(
  parameter  int WIDTH    = 26,
  parameter  int CHANNELS = 5,
  parameter  int PHASE_W  = 8,
  localparam int CHAN_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [WIDTH-1:0]    DIV,
  input  logic                CFG_VALID,
  output logic                CFG_READY,
  input  logic [CHAN_W-1:0]   CFG_CHAN,
  input  logic [MODE_W-1:0]   CFG_MODE,
  input  logic [PHASE_W-1:0]  CFG_DUTY,
  output logic [CHANNELS-1:0] LED,
  output logic                TICK,
  output logic                COUT
);

  logic                tick;
  logic                cout;
  logic                wr_en;
  logic                rdy_q;
  logic [PHASE_W-1:0]  phase_p0;
  logic [CHANNELS-1:0] led_p1;

  mode_t              mode_sh  [CHANNELS];
  logic [PHASE_W-1:0] duty_sh  [CHANNELS];
  mode_t              mode_act [CHANNELS];
  logic [PHASE_W-1:0] duty_act [CHANNELS];

  function automatic logic led_drive(input mode_t m,
                                     input logic [PHASE_W-1:0] ph,
                                     input logic [PHASE_W-1:0] duty);
    case (m)
      MODE_OFF:   led_drive = 1'b0;
      MODE_ON:    led_drive = 1'b1;
      MODE_BLINK: led_drive = ph[PHASE_W-1];
      default:    led_drive = (ph < duty);
    endcase
  endfunction

  tick_prescaler #(
    .WIDTH(WIDTH)
  ) u_prescaler (
    .CLK  (CLK),
    .RESET(RESET),
    .DIV  (DIV),
    .TICK (tick)
  );

  assign cout  = tick && (phase_p0 == '1);
  // rdy_q is cleared by reset and sets one edge after release, which keeps
  // the port low for the first post-reset cycle; RESET gates it directly.
  assign CFG_READY = rdy_q && !RESET;
  assign wr_en     = CFG_VALID && CFG_READY;
  assign TICK      = tick;
  assign COUT      = cout;
  // The LED register only clears on the first reset edge; masking with
  // RESET keeps the pins dark for the whole reset interval.
  assign LED       = led_p1 & {CHANNELS{!RESET}};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rdy_q    <= 1'b0;
      phase_p0 <= '0;
      led_p1   <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        mode_sh[i]  <= MODE_OFF;
        duty_sh[i]  <= '0;
        mode_act[i] <= MODE_OFF;
        duty_act[i] <= '0;
      end
    end else begin
      rdy_q <= 1'b1;
      // stage p0: shared phase counter
      if (tick) begin
        phase_p0 <= phase_p0 + PHASE_W'(1);
      end
      for (int i = 0; i < CHANNELS; i++) begin
        // Indices past CHANNELS-1 match no channel, so such writes vanish.
        if (wr_en && (CFG_CHAN == CHAN_W'(i))) begin
          mode_sh[i] <= CFG_MODE;
          duty_sh[i] <= CFG_DUTY;
        end
        // A write landing in the wrap cycle bypasses the shadow so it is not
        // delayed by a whole period.
        if (cout) begin
          if (wr_en && (CFG_CHAN == CHAN_W'(i))) begin
            mode_act[i] <= CFG_MODE;
            duty_act[i] <= CFG_DUTY;
          end else begin
            mode_act[i] <= mode_sh[i];
            duty_act[i] <= duty_sh[i];
          end
        end
        // stage p1: registered LED drive
        led_p1[i] <= led_drive(mode_act[i], phase_p0, duty_act[i]);
      end
    end
  end

endmodule

// File: tb/tb_led_blinker_bank.sv
module tb_led_blinker_bank;

  localparam int WIDTH    = 26;
  localparam int CHANNELS = 5;
  localparam int PHASE_W  = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [WIDTH-1:0]    div;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [2:0]          cfg_chan;
  logic [1:0]          cfg_mode;
  logic [PHASE_W-1:0]  cfg_duty;
  logic [CHANNELS-1:0] led;
  logic                tick;
  logic                cout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  led_blinker_bank #(
    .WIDTH   (WIDTH),
    .CHANNELS(CHANNELS),
    .PHASE_W (PHASE_W)
  ) dut (
    .CLK      (clk),
    .RESET    (rst),
    .DIV      (div),
    .CFG_VALID(cfg_valid),
    .CFG_READY(cfg_ready),
    .CFG_CHAN (cfg_chan),
    .CFG_MODE (cfg_mode),
    .CFG_DUTY (cfg_duty),
    .LED      (led),
    .TICK     (tick),
    .COUT     (cout)
  );

  typedef struct {
    logic                rst;
    logic [WIDTH-1:0]    div;
    logic                valid;
    logic [2:0]          chan;
    logic [1:0]          mode;
    logic [PHASE_W-1:0]  duty;
    logic [CHANNELS-1:0] led;
    logic                tick;
    logic                cout;
    logic                ready;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input int cyc,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [WIDTH-1:0] d);
    rst       = 1'b1;
    div       = d;
    cfg_valid = 1'b0;
    cfg_chan  = '0;
    cfg_mode  = '0;
    cfg_duty  = '0;
    step();
    step();
  endtask

  initial begin
    //          rst   div     vld   chan  mode  duty   led      tick  cout  ready
    vecs[0]  = '{1'b1, 26'd4, 1'b0, 3'd0, 2'd0, 8'd0,  5'b00000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 26'd4, 1'b0, 3'd0, 2'd0, 8'd0,  5'b00000, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 26'd4, 1'b0, 3'd0, 2'd0, 8'd0,  5'b00000, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 26'd4, 1'b0, 3'd0, 2'd0, 8'd0,  5'b00000, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 26'd4, 1'b0, 3'd0, 2'd0, 8'd0,  5'b00000, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 26'd4, 1'b1, 3'd7, 2'd1, 8'd5,  5'b00000, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 26'd4, 1'b1, 3'd1, 2'd1, 8'd0,  5'b00000, 1'b0, 1'b0, 1'b1};
    // count is 2 here; lowering DIV to 2 makes this cycle terminal
    vecs[7]  = '{1'b0, 26'd2, 1'b0, 3'd0, 2'd0, 8'd0,  5'b00000, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 26'd2, 1'b0, 3'd0, 2'd0, 8'd0,  5'b00000, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 26'd2, 1'b0, 3'd0, 2'd0, 8'd0,  5'b00000, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 26'd0, 1'b0, 3'd0, 2'd0, 8'd0,  5'b00000, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 26'd0, 1'b0, 3'd0, 2'd0, 8'd0,  5'b00000, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 26'd1, 1'b0, 3'd0, 2'd0, 8'd0,  5'b00000, 1'b1, 1'b0, 1'b1};

    // Table: reset, first cycles after release, DIV change, DIV=0/1
    do_reset(26'd4);
    for (int k = 0; k < 13; k++) begin
      rst       = vecs[k].rst;
      div       = vecs[k].div;
      cfg_valid = vecs[k].valid;
      cfg_chan  = vecs[k].chan;
      cfg_mode  = vecs[k].mode;
      cfg_duty  = vecs[k].duty;
      #1;
      chk("vec_led",   k, led,       vecs[k].led);
      chk("vec_tick",  k, tick,      vecs[k].tick);
      chk("vec_cout",  k, cout,      vecs[k].cout);
      chk("vec_ready", k, cfg_ready, vecs[k].ready);
      step();
    end

    // DIV=4, no writes: TICK on cycles 3,7,11,...; LED dark
    do_reset(26'd4);
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      chk("div4_tick", c, tick, (c % 4) == 3);
      chk("div4_led",  c, led, 0);
      step();
    end

    // DIV=0: TICK every cycle, COUT every 256 cycles
    do_reset(26'd0);
    rst = 1'b0;
    for (int c = 0; c < 520; c++) begin
      #1;
      chk("div0_tick", c, tick, 1);
      chk("div0_cout", c, cout, (c % 256) == 255);
      step();
    end

    // ch2 PWM duty 64 at DIV=1: active after the COUT in cycle 255
    do_reset(26'd1);
    rst = 1'b0;
    for (int c = 0; c < 600; c++) begin
      cfg_valid = (c == 1);
      cfg_chan  = 3'd2;
      cfg_mode  = 2'd3;
      cfg_duty  = 8'd64;
      #1;
      if (c < 2) chk("pwm_ready", c, cfg_ready, c == 1);
      chk("pwm_led", c, led,
          ((c - 1) >= 256 && ((c - 1) % 256) < 64) ? 5'b00100 : 5'b00000);
      step();
    end

    // ch0 BLINK written in the COUT cycle, plus a dropped write to ch7
    do_reset(26'd1);
    rst = 1'b0;
    for (int c = 0; c < 600; c++) begin
      cfg_valid = (c == 10) || (c == 255);
      cfg_chan  = (c == 10) ? 3'd7 : 3'd0;
      cfg_mode  = (c == 10) ? 2'd1 : 2'd2;
      cfg_duty  = (c == 10) ? 8'd255 : 8'd0;
      #1;
      if (c == 255) chk("blink_cout", c, cout, 1);
      if (c == 10 || c == 255) chk("blink_ready", c, cfg_ready, 1);
      chk("blink_led", c, led,
          ((c - 1) >= 256 && ((c - 1) % 256) >= 128) ? 5'b00001 : 5'b00000);
      step();
    end

    // ch1 ON, then reset at phase 100 with a write presented during reset
    do_reset(26'd1);
    rst = 1'b0;
    for (int c = 0; c < 356; c++) begin
      cfg_valid = (c == 1);
      cfg_chan  = 3'd1;
      cfg_mode  = 2'd1;
      cfg_duty  = 8'd0;
      #1;
      chk("on_led", c, led, (c >= 257) ? 5'b00010 : 5'b00000);
      step();
    end
    rst       = 1'b1;
    cfg_valid = 1'b1;
    cfg_chan  = 3'd3;
    cfg_mode  = 2'd1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("rst_led",   c, led, 0);
      chk("rst_ready", c, cfg_ready, 0);
      chk("rst_tick",  c, tick, 0);
      chk("rst_cout",  c, cout, 0);
      step();
    end
    rst       = 1'b0;
    cfg_valid = 1'b0;
    for (int k = 0; k < 261; k++) begin
      #1;
      chk("post_ready", k, cfg_ready, k != 0);
      chk("post_led",   k, led, 0);
      chk("post_cout",  k, cout, k == 255);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
